// File: rtl/kvs_req_queue_if.sv
// Request stream bundle (key, flag, valid/ready) used on both sides of kvs_req_queue.
interface kvs_req_queue_if #(
  parameter int unsigned KEY_SIZE  = 96,
  parameter int unsigned FLAG_SIZE = 4
) ();
  logic [KEY_SIZE-1:0]  key;
  logic [FLAG_SIZE-1:0] flag;
  logic                 valid;
  logic                 ready;

  modport master (output key, output flag, output valid, input ready);
  modport slave  (input key, input flag, input valid, output ready);
endinterface

// File: rtl/kvs_req_queue.sv
// Request FIFO in front of the KVS database: caps outstanding ops, pairs responses, times out.
// Define KVS_REQ_STATS_EN to add the stat_accept/stat_issue/stat_timeout counters.
module kvs_req_queue #(
  parameter int unsigned KEY_SIZE        = 96,
  parameter int unsigned FLAG_SIZE       = 4,
  parameter int unsigned DEPTH_LOG2      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TIMEOUT_CYC     = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  kvs_req_queue_if.slave       s,
  kvs_req_queue_if.master      m,
  input  logic                 db_valid,
  input  logic [FLAG_SIZE-1:0] db_flag,
  output logic                 rsp_valid,
  output logic [FLAG_SIZE-1:0] rsp_flag,
  output logic                 rsp_timeout,
  output logic [7:0]           outstanding,
  output logic [15:0]          spurious_cnt
`ifdef KVS_REQ_STATS_EN
  ,
  output logic [31:0]          stat_accept,
  output logic [31:0]          stat_issue,
  output logic [31:0]          stat_timeout
`endif
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned PtrW   = DEPTH_LOG2 + 1;
  localparam int unsigned EntryW = KEY_SIZE + FLAG_SIZE;
  localparam logic [7:0]  MaxOut = MAX_OUTSTANDING[7:0];
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  logic [EntryW-1:0]    mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 full, empty, accept, load, issue;
  logic [EntryW-1:0]    head;

  logic                 m_loaded_q, m_loaded_d;
  logic [KEY_SIZE-1:0]  m_key_q, m_key_d;
  logic [FLAG_SIZE-1:0] m_flag_q, m_flag_d;

  state_e               state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic [7:0]           out_q, out_d;
  logic [15:0]          spur_q, spur_d;
  logic                 db_hit, tmo_fire;

  logic                 rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [FLAG_SIZE-1:0] rsp_flag_q, rsp_flag_d;

  // Pointer MSBs differ only when the write side has lapped the read side.
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign s.ready = !rst && !full;
  assign accept  = s.valid && s.ready;

  assign m.valid = m_loaded_q && (out_q < MaxOut);
  assign m.key   = m_key_q;
  assign m.flag  = m_flag_q;
  assign issue   = m.valid && m.ready;
  assign load    = !empty && (!m_loaded_q || issue);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PtrW'(accept);
    rd_ptr_d   = rd_ptr_q + PtrW'(load);
    m_loaded_d = m_loaded_q;
    m_key_d    = m_key_q;
    m_flag_d   = m_flag_q;
    if (load) begin
      m_loaded_d = 1'b1;
      m_key_d    = head[EntryW-1:FLAG_SIZE];
      m_flag_d   = head[FLAG_SIZE-1:0];
    end else if (issue) begin
      m_loaded_d = 1'b0;
    end
  end

  // Timeout FSM and outstanding count share one block so the IDLE return sees the final count.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    tmo_fire = 1'b0;
    db_hit   = db_valid && (out_q != 8'd0);
    spur_d   = spur_q;
    if (db_valid && (out_q == 8'd0) && (spur_q != 16'hFFFF)) begin
      spur_d = spur_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        timer_d = 16'd0;
        if (issue) state_d = StWait;
      end
      StWait: begin
        if (db_valid) begin
          timer_d = 16'd0;
        end else if (timer_q == TmoLast) begin
          tmo_fire = 1'b1;
          timer_d  = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    out_d = out_q + 8'(issue) - 8'(db_hit || tmo_fire);
    if ((state_q == StWait) && (out_d == 8'd0)) begin
      state_d = StIdle;
      timer_d = 16'd0;
    end

    rsp_valid_d   = db_hit || tmo_fire;
    rsp_flag_d    = db_hit ? db_flag : '0;
    rsp_timeout_d = tmo_fire;
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s.key, s.flag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      m_loaded_q    <= 1'b0;
      m_key_q       <= '0;
      m_flag_q      <= '0;
      state_q       <= StIdle;
      timer_q       <= 16'd0;
      out_q         <= 8'd0;
      spur_q        <= 16'd0;
      rsp_valid_q   <= 1'b0;
      rsp_flag_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      m_loaded_q    <= m_loaded_d;
      m_key_q       <= m_key_d;
      m_flag_q      <= m_flag_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      out_q         <= out_d;
      spur_q        <= spur_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_flag_q    <= rsp_flag_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_flag     = rsp_flag_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign outstanding  = out_q;
  assign spurious_cnt = spur_q;

`ifdef KVS_REQ_STATS_EN
  logic [31:0] st_acc_q, st_iss_q, st_tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_acc_q <= 32'd0;
      st_iss_q <= 32'd0;
      st_tmo_q <= 32'd0;
    end else begin
      st_acc_q <= st_acc_q + 32'(accept);
      st_iss_q <= st_iss_q + 32'(issue);
      st_tmo_q <= st_tmo_q + 32'(tmo_fire);
    end
  end

  assign stat_accept  = st_acc_q;
  assign stat_issue   = st_iss_q;
  assign stat_timeout = st_tmo_q;
`endif

endmodule

// File: tb/tb_kvs_req_queue.sv
// Self-checking bench for kvs_req_queue: vector table, scoreboards, and multi-cycle corner cases.
module tb_kvs_req_queue;
  localparam int unsigned KeyW  = 96;
  localparam int unsigned FlagW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kvs_req_queue_if #(.KEY_SIZE(KeyW), .FLAG_SIZE(FlagW)) s_if ();
  kvs_req_queue_if #(.KEY_SIZE(KeyW), .FLAG_SIZE(FlagW)) m_if ();

  logic             db_valid;
  logic [FlagW-1:0] db_flag;
  logic             rsp_valid;
  logic [FlagW-1:0] rsp_flag;
  logic             rsp_timeout;
  logic [7:0]       outstanding;
  logic [15:0]      spurious_cnt;
`ifdef KVS_REQ_STATS_EN
  logic [31:0]      stat_accept, stat_issue, stat_timeout;
`endif

  kvs_req_queue #(
    .KEY_SIZE       (KeyW),
    .FLAG_SIZE      (FlagW),
    .DEPTH_LOG2     (4),
    .MAX_OUTSTANDING(8),
    .TIMEOUT_CYC    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (s_if.slave),
    .m           (m_if.master),
    .db_valid    (db_valid),
    .db_flag     (db_flag),
    .rsp_valid   (rsp_valid),
    .rsp_flag    (rsp_flag),
    .rsp_timeout (rsp_timeout),
    .outstanding (outstanding),
    .spurious_cnt(spurious_cnt)
`ifdef KVS_REQ_STATS_EN
    ,
    .stat_accept (stat_accept),
    .stat_issue  (stat_issue),
    .stat_timeout(stat_timeout)
`endif
  );

  typedef struct packed {
    logic [KeyW-1:0]  key;
    logic [FlagW-1:0] flag;
  } req_t;

  typedef struct {
    logic [KeyW-1:0]  key;
    logic [FlagW-1:0] flag;
    logic [FlagW-1:0] dbf;
    int               dly;
  } vec_t;

  req_t       exp_m[$];
  logic [4:0] exp_rsp[$];  // {timeout, flag}
  req_t       e_m;
  logic [4:0] e_r;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_issue = 0, n_rsp = 0, last_issue_cyc = 0, last_rsp_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Scoreboards: requests must emerge in accept order, responses in the order the bench expects.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_if.valid && m_if.ready) begin
        n_issue++;
        last_issue_cyc = cyc;
        if (exp_m.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_issue: unexpected issue key %0h flag %0h", m_if.key, m_if.flag);
        end else begin
          e_m = exp_m.pop_front();
          chk("sb_issue", {m_if.key, m_if.flag}, e_m);
        end
      end
      if (s_if.valid && s_if.ready) exp_m.push_back({s_if.key, s_if.flag});
      if (rsp_valid) begin
        n_rsp++;
        last_rsp_cyc = cyc;
        if (exp_rsp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_rsp: unexpected rsp flag %0h timeout %0b", rsp_flag, rsp_timeout);
        end else begin
          e_r = exp_rsp.pop_front();
          chk("sb_rsp", {rsp_timeout, rsp_flag}, e_r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs[4];
  int   lat, acc, stall, base_i, base_r;

  initial begin
    vecs[0] = '{96'hC0A80001_0050_1F90_00000001, 4'h1, 4'h2, 3};
    vecs[1] = '{96'hFFFFFFFF_FFFF_FFFF_FFFFFFFF, 4'hF, 4'h0, 1};
    vecs[2] = '{96'h00000000_0000_0000_00000000, 4'h0, 4'hF, 5};
    vecs[3] = '{96'h12345678_9ABC_DEF0_0BADF00D, 4'h8, 4'h9, 10};

    s_if.valid = 1'b0;
    s_if.key   = '0;
    s_if.flag  = '0;
    m_if.ready = 1'b0;
    db_valid   = 1'b0;
    db_flag    = '0;
    rst        = 1'b1;
    repeat (3) step();
    sample();
    chk("rst_s_ready", s_if.ready, 0);
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_m_key", m_if.key, 0);
    chk("rst_m_flag", m_if.flag, 0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_flag}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_spurious", spurious_cnt, 0);
    step();
    rst = 1'b0;
    sample();
    chk("s_ready_after_rst", s_if.ready, 1);

    // Single-request vectors
    step();
    m_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      step();
      s_if.valid = 1'b1;
      s_if.key   = vecs[i].key;
      s_if.flag  = vecs[i].flag;
      sample();
      chk("tv_s_ready", s_if.ready, 1);
      for (int k = 1; k <= 8; k++) begin
        step();
        if (k == 1) s_if.valid = 1'b0;
        sample();
        if (m_if.valid) begin
          lat = k;
          break;
        end
      end
      chk("tv_latency", lat, 2);
      chk("tv_m_key", m_if.key, vecs[i].key);
      chk("tv_m_flag", m_if.flag, vecs[i].flag);
      step();
      sample();
      chk("tv_outstanding_1", outstanding, 1);
      repeat (vecs[i].dly - 1) step();
      step();
      db_valid = 1'b1;
      db_flag  = vecs[i].dbf;
      exp_rsp.push_back({1'b0, vecs[i].dbf});
      step();
      db_valid = 1'b0;
      sample();
      chk("tv_rsp_valid", rsp_valid, 1);
      chk("tv_rsp_flag", rsp_flag, vecs[i].dbf);
      chk("tv_rsp_timeout", rsp_timeout, 0);
      chk("tv_outstanding_0", outstanding, 0);
    end

    // Back-pressure: 16 FIFO entries plus the output register
    step();
    m_if.ready = 1'b0;
    acc   = 0;
    stall = 0;
    s_if.valid = 1'b1;
    s_if.key   = {64'hBEEF_0000_CAFE_0000, 32'(acc)};
    s_if.flag  = 4'(acc);
    for (int k = 0; k < 40 && stall < 3; k++) begin
      sample();
      if (s_if.ready) begin
        acc++;
        stall = 0;
      end else begin
        stall++;
      end
      step();
      s_if.key  = {64'hBEEF_0000_CAFE_0000, 32'(acc)};
      s_if.flag = 4'(acc);
    end
    s_if.valid = 1'b0;
    chk("bp_accepted", acc, 17);
    sample();
    chk("bp_s_ready_low", s_if.ready, 0);

    // Outstanding cap, then drain with responses
    base_i = n_issue;
    step();
    m_if.ready = 1'b1;
    repeat (9) step();
    sample();
    chk("cap_issues", n_issue - base_i, 8);
    chk("cap_m_valid_low", m_if.valid, 0);
    chk("cap_outstanding", outstanding, 8);
    step();
    db_valid = 1'b1;
    db_flag  = 4'h5;
    exp_rsp.push_back({1'b0, 4'h5});
    step();
    db_valid = 1'b0;
    repeat (2) step();
    sample();
    chk("cap_one_more", n_issue - base_i, 9);
    chk("cap_outstanding_again", outstanding, 8);
    chk("cap_m_valid_low_again", m_if.valid, 0);
    for (int k = 0; k < 16; k++) begin
      step();
      db_valid = 1'b1;
      db_flag  = 4'(k);
      exp_rsp.push_back({1'b0, 4'(k)});
    end
    step();
    db_valid = 1'b0;
    repeat (3) step();
    sample();
    chk("bp_all_issued", n_issue - base_i, 17);
    chk("bp_outstanding_0", outstanding, 0);
    chk("bp_sb_m_empty", exp_m.size(), 0);
    chk("bp_sb_rsp_empty", exp_rsp.size(), 0);

    // Timeout: no response at all
    base_r = n_rsp;
    step();
    s_if.valid = 1'b1;
    s_if.key   = 96'hAAAA_5555_0000_1111_2222_3333;
    s_if.flag  = 4'h3;
    exp_rsp.push_back({1'b1, 4'h0});
    step();
    s_if.valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      sample();
      if (n_rsp != base_r) break;
    end
    chk("tmo_rsp_count", n_rsp - base_r, 1);
    chk("tmo_delay", last_rsp_cyc - last_issue_cyc, 17);
    chk("tmo_rsp_timeout", rsp_timeout, 1);
    chk("tmo_rsp_flag", rsp_flag, 0);
    chk("tmo_outstanding", outstanding, 0);

    // Real response in the expiry cycle wins
    base_i = n_issue;
    step();
    s_if.valid = 1'b1;
    s_if.key   = 96'h0000_0000_0000_0000_0000_0C01;
    s_if.flag  = 4'h4;
    step();
    s_if.valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (n_issue != base_i) break;
      step();
    end
    repeat (16) step();
    db_valid = 1'b1;
    db_flag  = 4'hA;
    exp_rsp.push_back({1'b0, 4'hA});
    step();
    db_valid = 1'b0;
    sample();
    chk("coll_rsp_valid", rsp_valid, 1);
    chk("coll_rsp_timeout", rsp_timeout, 0);
    chk("coll_rsp_flag", rsp_flag, 4'hA);
    base_r = n_rsp;
    repeat (20) step();
    sample();
    chk("coll_no_extra_rsp", n_rsp - base_r, 0);
    chk("coll_outstanding", outstanding, 0);

    // Issue coincident with a response
    base_i = n_issue;
    step();
    s_if.valid = 1'b1;
    s_if.key   = 96'h1;
    s_if.flag  = 4'h1;
    step();
    s_if.valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (n_issue != base_i) break;
      step();
    end
    step();
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.key   = 96'h2;
    s_if.flag  = 4'h2;
    step();
    s_if.valid = 1'b0;
    repeat (2) step();
    sample();
    chk("coll2_loaded", m_if.valid, 1);
    chk("coll2_outstanding_pre", outstanding, 1);
    step();
    m_if.ready = 1'b1;
    db_valid   = 1'b1;
    db_flag    = 4'h6;
    exp_rsp.push_back({1'b0, 4'h6});
    sample();
    chk("coll2_issue", m_if.valid && m_if.ready, 1);
    step();
    db_valid = 1'b0;
    sample();
    chk("coll2_outstanding_net", outstanding, 1);
    chk("coll2_rsp_valid", rsp_valid, 1);
    step();
    db_valid = 1'b1;
    db_flag  = 4'h7;
    exp_rsp.push_back({1'b0, 4'h7});
    step();
    db_valid = 1'b0;
    sample();
    chk("coll2_outstanding_0", outstanding, 0);

    // Spurious responses
    base_r = n_rsp;
    for (int k = 0; k < 3; k++) begin
      step();
      db_valid = 1'b1;
      db_flag  = 4'(k + 1);
      step();
      db_valid = 1'b0;
    end
    repeat (2) step();
    sample();
    chk("spur_cnt", spurious_cnt, 3);
    chk("spur_no_rsp", n_rsp - base_r, 0);

    // Reset in the middle of a burst with requests outstanding
    step();
    s_if.valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_if.key  = {64'hD00D, 32'(k)};
      s_if.flag = 4'(k);
      step();
    end
    s_if.valid = 1'b0;
    repeat (3) step();
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_if.key  = {64'hF00D, 32'(k)};
      s_if.flag = 4'(k + 8);
      step();
    end
    s_if.valid = 1'b0;
    sample();
    chk("mid_outstanding_pre", outstanding, 2);
    step();
    rst = 1'b1;
    exp_m.delete();
    exp_rsp.delete();
    step();
    rst = 1'b0;
    sample();
    chk("mid_rst_m_valid", m_if.valid, 0);
    chk("mid_rst_m_key", m_if.key, 0);
    chk("mid_rst_m_flag", m_if.flag, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_timeout, rsp_flag}, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_spurious", spurious_cnt, 0);
    chk("mid_rst_s_ready", s_if.ready, 1);
    base_i = n_issue;
    base_r = n_rsp;
    step();
    m_if.ready = 1'b1;
    repeat (25) step();
    sample();
    chk("mid_no_issue", n_issue - base_i, 0);
    chk("mid_no_rsp", n_rsp - base_r, 0);
    chk("mid_outstanding_post", outstanding, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
